// File: rtl/calc_pkg.sv
// Shared key codes, operator encodings and FSM states for the calculator
// entry path between button_reader, input_parser and the ALU stage.
package calc_pkg;

    localparam logic [4:0] KEY_AC  = 5'd16;
    localparam logic [4:0] KEY_ADD = 5'd17;
    localparam logic [4:0] KEY_SUB = 5'd18;
    localparam logic [4:0] KEY_MUL = 5'd19;
    localparam logic [4:0] KEY_DIV = 5'd20;
    localparam logic [4:0] KEY_EQ  = 5'd21;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_OP,
        ST_ENTER_B,
        ST_ISSUE,
        ST_WAIT,
        ST_SHOW,
        ST_ERR
    } state_t;

    function automatic logic is_digit(input logic [4:0] code);
        return code <= 5'd9;
    endfunction

    function automatic logic is_oper(input logic [4:0] code);
        return (code >= KEY_ADD) && (code <= KEY_DIV);
    endfunction

    // Operator keys are contiguous, so the op is the offset from ADD.
    function automatic logic [1:0] key_op(input logic [4:0] code);
        return 2'(code - KEY_ADD);
    endfunction

endpackage

// File: rtl/input_parser_if.sv
// Key stream, ALU request/result and display bundle of input_parser.
// slave is the parser side; master is the key source / ALU / display side.
interface input_parser_if #(
    parameter int DIGITS = 8
);
    localparam int W = 4 * DIGITS;

    logic [4:0]   i_data;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] o_op_a;
    logic         o_op_a_neg;
    logic [W-1:0] o_op_b;
    logic [1:0]   o_op;
    logic         o_op_valid;
    logic         i_op_ready;
    logic [W-1:0] i_res;
    logic         i_res_neg;
    logic         i_res_err;
    logic         i_res_valid;
    logic [W-1:0] o_display;
    logic         o_disp_neg;
    logic         o_err;

    modport slave (
        input  i_data, i_valid, i_op_ready,
        input  i_res, i_res_neg, i_res_err, i_res_valid,
        output o_ready, o_op_a, o_op_a_neg, o_op_b, o_op, o_op_valid,
        output o_display, o_disp_neg, o_err
    );

    modport master (
        output i_data, i_valid, i_op_ready,
        output i_res, i_res_neg, i_res_err, i_res_valid,
        input  o_ready, o_op_a, o_op_a_neg, o_op_b, o_op, o_op_valid,
        input  o_display, o_disp_neg, o_err
    );

endinterface

// File: rtl/bcd_entry_reg.sv
// BCD operand register: shifts in one digit at a time from the right,
// tracks how many digits are held, and can be cleared or loaded whole.
module bcd_entry_reg #(
    parameter int DIGITS = 8,
    localparam int W = 4 * DIGITS,
    localparam int CW = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [W-1:0]  load_value,
    input  logic [CW-1:0] load_count,
    input  logic          push,
    input  logic [3:0]    digit,
    output logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          full
);

    assign full = (count == CW'(DIGITS));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_value;
            count <= load_count;
        end else if (push && !full) begin
            value <= {value[W-5:0], digit};
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/input_parser.sv
// Calculator entry FSM: builds BCD operands from key codes, issues A op B
// to the ALU, chains results back into A and drives the display.
module input_parser
    import calc_pkg::*;
#(
    parameter int DIGITS = 8,
    localparam int W = 4 * DIGITS,
    localparam int CW = $clog2(DIGITS + 1)
) (
    input logic            clk,
    input logic            rst,
    input_parser_if.slave  bus
);

    state_t state, state_n;

    logic [1:0] op, op_n;
    logic [1:0] pend, pend_n;
    logic       chain, chain_n;
    logic       a_neg, a_neg_n;

    logic [W-1:0]  a_value, b_value;
    logic [CW-1:0] a_count, b_count;
    logic          a_full, b_full;

    logic          a_clr, a_load, a_push;
    logic [W-1:0]  a_lval;
    logic [CW-1:0] a_lcnt;
    logic          b_clr, b_load, b_push;
    logic [W-1:0]  b_lval;
    logic [CW-1:0] b_lcnt;

    logic       ready;
    logic       take;
    logic [4:0] key;
    logic [3:0] d;
    logic       k_dig, k_op, k_eq, k_ac;
    logic       a_ok, b_ok;

    assign ready = (state != ST_ISSUE) && (state != ST_WAIT);
    assign take  = bus.i_valid && ready;
    assign key   = bus.i_data;
    assign d     = key[3:0];
    assign k_dig = take && is_digit(key);
    assign k_op  = take && is_oper(key);
    assign k_eq  = take && (key == KEY_EQ);
    assign k_ac  = take && (key == KEY_AC);

    // A leading zero is dropped: it would not change the value anyway.
    assign a_ok = !a_full && !((a_count == '0) && (d == 4'd0));
    assign b_ok = !b_full && !((b_count == '0) && (d == 4'd0));

    bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_a (
        .clk        (clk),
        .rst        (rst),
        .clr        (a_clr),
        .load       (a_load),
        .load_value (a_lval),
        .load_count (a_lcnt),
        .push       (a_push),
        .digit      (d),
        .value      (a_value),
        .count      (a_count),
        .full       (a_full)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_b (
        .clk        (clk),
        .rst        (rst),
        .clr        (b_clr),
        .load       (b_load),
        .load_value (b_lval),
        .load_count (b_lcnt),
        .push       (b_push),
        .digit      (d),
        .value      (b_value),
        .count      (b_count),
        .full       (b_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ENTER_A;
            op    <= OP_ADD;
            pend  <= OP_ADD;
            chain <= 1'b0;
            a_neg <= 1'b0;
        end else begin
            state <= state_n;
            op    <= op_n;
            pend  <= pend_n;
            chain <= chain_n;
            a_neg <= a_neg_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op;
        pend_n  = pend;
        chain_n = chain;
        a_neg_n = a_neg;
        a_clr   = 1'b0;
        a_load  = 1'b0;
        a_push  = 1'b0;
        a_lval  = '0;
        a_lcnt  = '0;
        b_clr   = 1'b0;
        b_load  = 1'b0;
        b_push  = 1'b0;
        b_lval  = '0;
        b_lcnt  = '0;

        if (k_ac) begin
            a_clr   = 1'b1;
            b_clr   = 1'b1;
            a_neg_n = 1'b0;
            op_n    = OP_ADD;
            pend_n  = OP_ADD;
            chain_n = 1'b0;
            state_n = ST_ENTER_A;
        end else begin
            case (state)
                ST_ENTER_A: begin
                    unique case (1'b1)
                        k_dig: a_push = a_ok;
                        k_op: begin
                            op_n    = key_op(key);
                            state_n = ST_OP;
                        end
                        default: ;
                    endcase
                end
                ST_OP: begin
                    unique case (1'b1)
                        k_dig: begin
                            b_load  = 1'b1;
                            b_lval  = W'(d);
                            b_lcnt  = (d != 4'd0) ? CW'(1) : '0;
                            state_n = ST_ENTER_B;
                        end
                        k_op: op_n = key_op(key);
                        default: ;
                    endcase
                end
                ST_ENTER_B: begin
                    unique case (1'b1)
                        k_dig: b_push = b_ok;
                        k_op: begin
                            pend_n  = key_op(key);
                            chain_n = 1'b1;
                            state_n = ST_ISSUE;
                        end
                        k_eq: begin
                            chain_n = 1'b0;
                            state_n = ST_ISSUE;
                        end
                        default: ;
                    endcase
                end
                ST_ISSUE: begin
                    if (bus.i_op_ready) begin
                        state_n = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_res_valid) begin
                        if (bus.i_res_err) begin
                            state_n = ST_ERR;
                        end else begin
                            // Full count locks a result against digit entry.
                            a_load  = 1'b1;
                            a_lval  = bus.i_res;
                            a_lcnt  = CW'(DIGITS);
                            a_neg_n = bus.i_res_neg;
                            b_clr   = 1'b1;
                            if (chain) begin
                                op_n    = pend;
                                state_n = ST_OP;
                            end else begin
                                state_n = ST_SHOW;
                            end
                        end
                    end
                end
                ST_SHOW: begin
                    unique case (1'b1)
                        k_dig: begin
                            a_load  = 1'b1;
                            a_lval  = W'(d);
                            a_lcnt  = (d != 4'd0) ? CW'(1) : '0;
                            a_neg_n = 1'b0;
                            state_n = ST_ENTER_A;
                        end
                        k_op: begin
                            op_n    = key_op(key);
                            state_n = ST_OP;
                        end
                        default: ;
                    endcase
                end
                ST_ERR: ;
                default: state_n = ST_ENTER_A;
            endcase
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_op_valid = (state == ST_ISSUE);
    assign bus.o_op_a     = a_value;
    assign bus.o_op_a_neg = a_neg;
    assign bus.o_op_b     = b_value;
    assign bus.o_op       = op;
    assign bus.o_display  = (state == ST_ENTER_B) ? b_value : a_value;
    assign bus.o_disp_neg = (state == ST_ENTER_B) ? 1'b0 : a_neg;
    assign bus.o_err      = (state == ST_ERR);

endmodule

// File: tb/tb_input_parser.sv
// Directed and random key sequences against a decimal-arithmetic model
// of the calculator, with the bench acting as the ALU.
module tb_input_parser;

    localparam int DIGITS = 8;
    localparam longint LIM = 100000000;
    localparam longint PUSH_LIM = 10000000;

    localparam int M_EA   = 0;
    localparam int M_OP   = 1;
    localparam int M_EB   = 2;
    localparam int M_BUSY = 3;
    localparam int M_SHOW = 4;
    localparam int M_ERR  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    int     m_st;
    longint m_a, m_b;
    logic   m_a_neg, m_a_lock, m_chain;
    logic [1:0] m_op, m_pend;

    input_parser_if #(.DIGITS(DIGITS)) bus ();

    input_parser #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] to_bcd(input longint v);
        logic [31:0] r;
        longint t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_st = M_EA;
        m_a = 0;
        m_b = 0;
        m_a_neg = 1'b0;
        m_a_lock = 1'b0;
        m_chain = 1'b0;
        m_op = 2'd0;
        m_pend = 2'd0;
    endtask

    task automatic model_key(input int k);
        if (m_st == M_ERR) begin
            if (k == 16) model_clear();
        end else if (k == 16) begin
            model_clear();
        end else if (k <= 9) begin
            case (m_st)
                M_EA: if (!m_a_lock && m_a < PUSH_LIM) m_a = m_a * 10 + k;
                M_OP: begin
                    m_b = k;
                    m_st = M_EB;
                end
                M_EB: if (m_b < PUSH_LIM) m_b = m_b * 10 + k;
                M_SHOW: begin
                    m_a = k;
                    m_a_neg = 1'b0;
                    m_a_lock = 1'b0;
                    m_st = M_EA;
                end
                default: ;
            endcase
        end else if (k >= 17 && k <= 20) begin
            case (m_st)
                M_EA, M_OP, M_SHOW: begin
                    m_op = 2'(k - 17);
                    m_st = M_OP;
                end
                M_EB: begin
                    m_pend = 2'(k - 17);
                    m_chain = 1'b1;
                    m_st = M_BUSY;
                end
                default: ;
            endcase
        end else if (k == 21) begin
            if (m_st == M_EB) begin
                m_chain = 1'b0;
                m_st = M_BUSY;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".disp"}, bus.o_display,
            (m_st == M_EB) ? to_bcd(m_b) : to_bcd(m_a));
        chk({tag, ".dneg"}, bus.o_disp_neg, (m_st == M_EB) ? 1'b0 : m_a_neg);
        chk({tag, ".err"}, bus.o_err, m_st == M_ERR);
        chk({tag, ".rdy"}, bus.o_ready, m_st != M_BUSY);
        chk({tag, ".opv"}, bus.o_op_valid, m_st == M_BUSY);
    endtask

    task automatic key(input int k);
        bus.i_data = 5'(k);
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        model_key(k);
        check_state($sformatf("key%0d", k));
    endtask

    task automatic serve_alu(input int hold, input int gap);
        longint sa, r;
        logic err;
        for (int h = 0; h <= hold; h++) begin
            chk("req.opv", bus.o_op_valid, 1'b1);
            chk("req.a", bus.o_op_a, to_bcd(m_a));
            chk("req.aneg", bus.o_op_a_neg, m_a_neg);
            chk("req.b", bus.o_op_b, to_bcd(m_b));
            chk("req.op", bus.o_op, m_op);
            if (h < hold) @(negedge clk);
        end
        bus.i_op_ready = 1'b1;
        @(negedge clk);
        bus.i_op_ready = 1'b0;
        chk("wait.opv", bus.o_op_valid, 1'b0);
        chk("wait.rdy", bus.o_ready, 1'b0);
        repeat (gap) @(negedge clk);
        sa = m_a_neg ? -m_a : m_a;
        err = 1'b0;
        r = 0;
        case (m_op)
            2'd0: r = sa + m_b;
            2'd1: r = sa - m_b;
            2'd2: r = sa * m_b;
            default: begin
                if (m_b == 0) err = 1'b1;
                else r = sa / m_b;
            end
        endcase
        if (r >= LIM || r <= -LIM) err = 1'b1;
        bus.i_res = err ? 32'h0 : to_bcd(r < 0 ? -r : r);
        bus.i_res_neg = !err && (r < 0);
        bus.i_res_err = err;
        bus.i_res_valid = 1'b1;
        @(negedge clk);
        bus.i_res_valid = 1'b0;
        bus.i_res_err = 1'b0;
        if (err) begin
            m_st = M_ERR;
        end else begin
            m_a = (r < 0) ? -r : r;
            m_a_neg = (r < 0);
            m_a_lock = 1'b1;
            m_b = 0;
            if (m_chain) begin
                m_op = m_pend;
                m_st = M_OP;
            end else begin
                m_st = M_SHOW;
            end
        end
        check_state("res");
    endtask

    task automatic keys(input int n, input int ks[10]);
        for (int i = 0; i < n; i++) key(ks[i]);
    endtask

    initial begin
        int k, r;
        bus.i_data = '0;
        bus.i_valid = 1'b0;
        bus.i_op_ready = 1'b0;
        bus.i_res = '0;
        bus.i_res_neg = 1'b0;
        bus.i_res_err = 1'b0;
        bus.i_res_valid = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_state("reset");
        chk("reset.disp0", bus.o_display, 32'h0);

        keys(3, '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0});
        chk("t1.disp", bus.o_display, 32'h123);

        keys(7, '{16, 1, 2, 17, 3, 4, 21, 0, 0, 0});
        chk("t2.a", bus.o_op_a, 32'h12);
        chk("t2.b", bus.o_op_b, 32'h34);
        chk("t2.op", bus.o_op, 2'd0);
        serve_alu(3, 1);
        chk("t2.disp", bus.o_display, 32'h46);

        keys(5, '{16, 9, 19, 2, 18, 0, 0, 0, 0, 0});
        chk("t3.a", bus.o_op_a, 32'h9);
        chk("t3.b", bus.o_op_b, 32'h2);
        chk("t3.op", bus.o_op, 2'd2);
        serve_alu(0, 0);
        chk("t3.chain_op", bus.o_op, 2'd1);
        chk("t3.disp", bus.o_display, 32'h18);
        keys(2, '{5, 21, 0, 0, 0, 0, 0, 0, 0, 0});
        chk("t3.a2", bus.o_op_a, 32'h18);
        chk("t3.b2", bus.o_op_b, 32'h5);
        chk("t3.op2", bus.o_op, 2'd1);
        serve_alu(1, 2);
        chk("t3.disp2", bus.o_display, 32'h13);

        keys(10, '{16, 1, 2, 3, 4, 5, 6, 7, 8, 9});
        chk("t4.full", bus.o_display, 32'h12345678);
        keys(4, '{16, 0, 0, 7, 0, 0, 0, 0, 0, 0});
        chk("t4.lead0", bus.o_display, 32'h7);

        keys(5, '{16, 8, 20, 0, 21, 0, 0, 0, 0, 0});
        serve_alu(0, 0);
        chk("t5.err", bus.o_err, 1'b1);
        keys(2, '{5, 17, 0, 0, 0, 0, 0, 0, 0, 0});
        chk("t5.err_hold", bus.o_err, 1'b1);
        key(16);
        chk("t5.ac_disp", bus.o_display, 32'h0);
        chk("t5.ac_err", bus.o_err, 1'b0);

        keys(4, '{1, 17, 2, 21, 0, 0, 0, 0, 0, 0});
        bus.i_op_ready = 1'b1;
        @(negedge clk);
        bus.i_op_ready = 1'b0;
        chk("t6.in_wait", bus.o_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_state("t6.rst");
        bus.i_res = 32'h99;
        bus.i_res_valid = 1'b1;
        @(negedge clk);
        bus.i_res_valid = 1'b0;
        check_state("t6.stray_res");
        keys(4, '{3, 17, 4, 21, 0, 0, 0, 0, 0, 0});
        bus.i_data = 5'd5;
        bus.i_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_valid = 1'b0;
        serve_alu(0, 0);
        chk("t6.no_key", bus.o_display, 32'h7);

        key(16);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) k = $urandom_range(0, 9);
            else if (r < 75) k = $urandom_range(17, 20);
            else if (r < 87) k = 21;
            else if (r < 92) k = 16;
            else if (r < 96) k = $urandom_range(10, 15);
            else k = $urandom_range(22, 31);
            key(k);
            if (m_st == M_BUSY) serve_alu($urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
